// File: rtl/flap_input_conditioner_if.sv
// Button inputs, enable and conditioned action outputs of the flap input stage.
// The bench drives through master; the conditioner sits on slave.
interface flap_input_conditioner_if;
    logic ena;
    logic btn_up_i;
    logic btn_down_i;
    logic up_pulse_o;
    logic down_pulse_o;
    logic up_held_o;
    logic down_held_o;
    logic any_press_o;

    modport master (
        output ena, btn_up_i, btn_down_i,
        input  up_pulse_o, down_pulse_o, up_held_o, down_held_o, any_press_o
    );

    modport slave (
        input  ena, btn_up_i, btn_down_i,
        output up_pulse_o, down_pulse_o, up_held_o, down_held_o, any_press_o
    );
endinterface

// File: rtl/flap_input_conditioner.sv
// Synchronise, debounce and auto-repeat the UP/DOWN flap buttons.
// Emits one-cycle action pulses, debounced held levels and a fresh-press pulse.
//
// state     | meaning
// ST_IDLE   | waiting for a debounced rising edge (also forced while ena is low)
// ST_DELAY  | pressed, counting REPEAT_DELAY cycles to the first repeat pulse
// ST_REPEAT | held, pulsing every REPEAT_PERIOD cycles
module flap_input_conditioner #(
    parameter int CNT_W         = 18,
    parameter int DB_CYCLES     = 1000,
    parameter int REPEAT_DELAY  = 200000,
    parameter int REPEAT_PERIOD = 50000
) (
    input logic                     clk,
    input logic                     rst,
    flap_input_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic             RPT_EN   = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] DB_TC    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_TC   = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0] raw;
    logic [1:0] db_v;
    logic [1:0] press_v;
    logic [1:0] evt_v;

    logic up_pulse_q, down_pulse_q, up_held_q, down_held_q, any_press_q;

    assign raw = {bus.btn_down_i, bus.btn_up_i};

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1, sync2, db, db_d;
        logic             press, rep;
        logic [CNT_W-1:0] db_cnt, rp_cnt;
        state_t           state;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                db     <= 1'b0;
                db_d   <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= raw[ch];
                sync2 <= sync1;
                db_d  <= db;
                if (sync2 == db) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_TC) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end
        end

        // A release seen on a terminal-count cycle wins, so no stray repeat.
        always_comb begin
            press = 1'b0;
            rep   = 1'b0;
            if (bus.ena) begin
                case (state)
                    ST_IDLE:   press = db && !db_d;
                    ST_DELAY:  rep   = db && (rp_cnt == DELAY_TC);
                    ST_REPEAT: rep   = db && (rp_cnt == RPT_TC);
                    default:   rep   = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst || !bus.ena) begin
                state  <= ST_IDLE;
                rp_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press && RPT_EN) begin
                            state  <= ST_DELAY;
                            rp_cnt <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!db) begin
                            state  <= ST_IDLE;
                            rp_cnt <= '0;
                        end else if (rep) begin
                            state  <= ST_REPEAT;
                            rp_cnt <= '0;
                        end else begin
                            rp_cnt <= rp_cnt + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!db) begin
                            state  <= ST_IDLE;
                            rp_cnt <= '0;
                        end else if (rep) begin
                            rp_cnt <= '0;
                        end else begin
                            rp_cnt <= rp_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        rp_cnt <= '0;
                    end
                endcase
            end
        end

        assign db_v[ch]    = db;
        assign press_v[ch] = press;
        assign evt_v[ch]   = press | rep;
    end

    // UP wins a coincidence; the DOWN pulse is dropped rather than deferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            up_held_q    <= 1'b0;
            down_held_q  <= 1'b0;
            any_press_q  <= 1'b0;
        end else begin
            up_pulse_q   <= evt_v[0];
            down_pulse_q <= evt_v[1] & ~evt_v[0];
            up_held_q    <= db_v[0];
            down_held_q  <= db_v[1];
            any_press_q  <= press_v[0] | press_v[1];
        end
    end

    assign bus.up_pulse_o   = up_pulse_q;
    assign bus.down_pulse_o = down_pulse_q;
    assign bus.up_held_o    = up_held_q;
    assign bus.down_held_o  = down_held_q;
    assign bus.any_press_o  = any_press_q;

endmodule

// File: doc/flap_input_conditioner.md
Name: flap_input_conditioner

Overview:
- Upstream input stage of the Flappy Bird game core; sits between the raw ui_in button pins and the bird physics/game FSM.
- Synchronises and debounces the UP (ui_in[0]) and DOWN (ui_in[1]) buttons.
- Produces single-cycle action pulses with optional hold auto-repeat, plus stable held levels and a fresh-press "any key" pulse used for game start.

Parameters:
- CNT_W, 18, width of all internal counters.
- DB_CYCLES, 1000, consecutive cycles a synchronised input must differ from the debounced state before it is accepted; range 1..2^CNT_W-1.
- REPEAT_DELAY, 200000, cycles from the initial press pulse to the first auto-repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 50000, cycles between subsequent auto-repeat pulses; must be ≥1 when REPEAT_DELAY≠0.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ena, input, 1, design enable; low gates all pulses.
- btn_up_i, input, 1, raw asynchronous UP button (ui_in[0]).
- btn_down_i, input, 1, raw asynchronous DOWN button (ui_in[1]).
- up_pulse_o, output, 1, one-cycle UP action, press or repeat.
- down_pulse_o, output, 1, one-cycle DOWN action, press or repeat.
- up_held_o, output, 1, debounced UP level.
- down_held_o, output, 1, debounced DOWN level.
- any_press_o, output, 1, one-cycle pulse on any fresh debounced press; repeats excluded.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, sampled on the rising clk edge. All outputs are registered.
- Reset: all outputs 0, synchroniser FFs 0, debounced states 0, counters 0, both FSMs IDLE.
- Synchroniser: 2-FF chain per button.
- Debounce, per channel:
  - Counter clears on any cycle where sync == db.
  - While sync != db, the counter increments.
  - When the counter reaches DB_CYCLES-1 and sync still differs, db <= sync and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never change db.
- Held outputs: *_held_o = db, updated on the edge after db changes.
- Latency: a clean input transition reaches *_held_o / fresh pulse DB_CYCLES+3 edges after the first edge that samples it.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT; the repeat counter clears on every state entry.
  - IDLE: db rising edge -> press pulse. Go to DELAY, or stay IDLE (no repeats) if REPEAT_DELAY==0.
  - DELAY: counter reaches REPEAT_DELAY-1 -> repeat pulse, go to REPEAT.
  - REPEAT: counter reaches REPEAT_PERIOD-1 -> repeat pulse, counter clears.
  - db low in any state -> IDLE, no pulse. Release on the same cycle as a repeat terminal count suppresses that pulse.
- Conflict: if UP and DOWN internal pulses coincide, up_pulse_o fires and the DOWN pulse is dropped, not deferred. Held levels are unaffected.
- any_press_o = registered OR of the fresh (IDLE->press) events of both channels. It is not subject to conflict suppression.
- ena low:
  - up_pulse_o, down_pulse_o and any_press_o are forced 0.
  - Both FSMs are held in IDLE.
  - Synchronisers, debounce and held outputs keep running.
  - A button already held when ena rises generates no press pulse until it is released and pressed again.
- rst mid-operation: everything returns to reset values on that edge; a held button re-qualifies through the full debounce after rst drops.
- Counters never wrap in normal use. Parameter legality is the integrator's responsibility; no saturation logic.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, ena=1 unless stated):
- Reset: hold rst 3 cycles with both buttons high -> all outputs 0 during reset. After release, up_held_o rises 7 edges later with a single up_pulse_o and any_press_o.
- Glitch reject: btn_up_i high for 3 cycles then low -> up_held_o, up_pulse_o and any_press_o stay 0 throughout.
- Auto-repeat: hold btn_up_i 40 cycles -> up_pulse_o at press cycle t, then t+10, t+15, t+20, t+25…. any_press_o only at t. Release -> no further pulses after db falls.
- Conflict: press both buttons on the same cycle -> up_pulse_o=1, down_pulse_o=0 on every coinciding pulse. Both held outputs go to 1. any_press_o is a single pulse.
- Enable gating: ena=0 while btn_down_i pressed -> down_held_o=1, no pulses. Raise ena while held -> still no pulse. Release and re-press -> down_pulse_o after 7 edges.
- Reset mid-repeat: assert rst during REPEAT -> outputs 0 next edge. Button still held after rst drops -> fresh press pulse after 7 edges, next repeat 10 cycles later.
